// File: rtl/branch_redirect_ctrl_if.sv
// Redirect bundle between the EX-stage branch resolution, fetch and branch_redirect_ctrl.
// The master side is the pipeline (EX + fetch); the slave side is the redirect controller.
interface branch_redirect_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_cond;
    logic        ex_ret;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_tgt;
    logic [31:0] ex_fall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;

    modport master (
        output ex_valid, ex_pc, ex_cond, ex_ret, ex_taken, ex_pred_taken, ex_tgt, ex_fall,
        output redir_ready,
        input  redir_valid, redir_pc
    );

    modport slave (
        input  ex_valid, ex_pc, ex_cond, ex_ret, ex_taken, ex_pred_taken, ex_tgt, ex_fall,
        input  redir_ready,
        output redir_valid, redir_pc
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch direction predictor (2-bit BHT) plus mispredict redirect/flush sequencer.
// Optional BRANCH_STATS_EN macro adds resolved-branch and redirect counters.
module branch_redirect_ctrl #(
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 if_pc,
    input  logic                        if_is_br,
    output logic                        if_pred_taken,
    branch_redirect_ctrl_if.slave       rif,
    output logic                        flush,
    output logic                        busy,
    output logic [31:0]                 br_count,
    output logic [31:0]                 mispred_count
);
    localparam int BHT_N = 2 ** BHT_IDX_W;
    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               redir_valid_r;
    logic [31:0]        redir_pc_r;
    logic               flush_r;
    logic               busy_r;
    logic [1:0]         bht_r [BHT_N];

    logic [BHT_IDX_W-1:0] if_idx_s;
    logic [BHT_IDX_W-1:0] ex_idx_s;
    logic                 idle_s;
    logic                 mispredict_s;
    logic                 bht_upd_s;
    logic [31:0]          target_s;
    logic [1:0]           bht_cur_s;
    logic [1:0]           bht_nxt_s;
    logic                 unused_s;

    assign if_idx_s      = if_pc[BHT_IDX_W+1:2];
    assign ex_idx_s      = rif.ex_pc[BHT_IDX_W+1:2];
    assign idle_s        = (state_r == ST_IDLE);
    assign mispredict_s  = rif.ex_valid & idle_s & (rif.ex_ret | (rif.ex_taken != rif.ex_pred_taken));
    assign bht_upd_s     = rif.ex_valid & rif.ex_cond & idle_s;
    assign if_pred_taken = bht_r[if_idx_s][1] & if_is_br;
    assign unused_s      = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0],
                             rif.ex_pc[31:BHT_IDX_W+2], rif.ex_pc[1:0]};

    // Redirect target selection and saturating next value of the resolving branch's counter.
    always_comb begin
        target_s  = (rif.ex_ret | rif.ex_taken) ? rif.ex_tgt : rif.ex_fall;
        bht_cur_s = bht_r[ex_idx_s];
        bht_nxt_s = bht_cur_s;
        if (rif.ex_taken) begin
            if (bht_cur_s != 2'b11) begin
                bht_nxt_s = bht_cur_s + 2'b01;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end else begin
            if (bht_cur_s != 2'b00) begin
                bht_nxt_s = bht_cur_s - 2'b01;
            end else begin
                bht_nxt_s = bht_cur_s;
            end
        end
    end

    // Branch history table; lookups in the update cycle still see the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (bht_upd_s) begin
            bht_r[ex_idx_s] <= bht_nxt_s;
        end
    end

    // Redirect/flush sequencer with registered handshake and flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            flush_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mispredict_s) begin
                        state_r       <= ST_REDIRECT;
                        redir_pc_r    <= target_s;
                        redir_valid_r <= 1'b1;
                        flush_r       <= 1'b1;
                        busy_r        <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (redir_valid_r && rif.redir_ready) begin
                        state_r       <= ST_FLUSH;
                        redir_valid_r <= 1'b0;
                        cnt_r         <= CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_IDLE;
                        flush_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= {CNT_W{1'b0}};
                    redir_valid_r <= 1'b0;
                    flush_r       <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign rif.redir_valid = redir_valid_r;
    assign rif.redir_pc    = redir_pc_r;
    assign flush           = flush_r;
    assign busy            = busy_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_r;
    logic [31:0] mispred_count_r;

    // Statistics: only right-path (IDLE) resolutions and redirects are counted; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_r      <= 32'd0;
            mispred_count_r <= 32'd0;
        end else begin
            if (rif.ex_valid && idle_s) begin
                br_count_r <= br_count_r + 32'd1;
            end
            if (mispredict_s) begin
                mispred_count_r <= mispred_count_r + 32'd1;
            end
        end
    end

    assign br_count      = br_count_r;
    assign mispred_count = mispred_count_r;
`else
    assign br_count      = 32'd0;
    assign mispred_count = 32'd0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (FLUSH_CYCLES=2, BHT_IDX_W=4).
module tb_branch_redirect_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_is_br;
    logic        if_pred_taken;
    logic        flush;
    logic        busy;
    logic [31:0] br_count;
    logic [31:0] mispred_count;
    int          total;
    int          bad;

    branch_redirect_ctrl_if rif ();

    branch_redirect_ctrl #(.BHT_IDX_W(4), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_is_br      (if_is_br),
        .if_pred_taken (if_pred_taken),
        .rif           (rif),
        .flush         (flush),
        .busy          (busy),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        rif.ex_valid      = 1'b0;
        rif.ex_pc         = 32'd0;
        rif.ex_cond       = 1'b0;
        rif.ex_ret        = 1'b0;
        rif.ex_taken      = 1'b0;
        rif.ex_pred_taken = 1'b0;
        rif.ex_tgt        = 32'd0;
        rif.ex_fall       = 32'd0;
    endtask

    task automatic ex_drive(input logic [31:0] pc, input logic cond, input logic ret,
                            input logic taken, input logic pred,
                            input logic [31:0] tgt, input logic [31:0] fall);
        rif.ex_valid      = 1'b1;
        rif.ex_pc         = pc;
        rif.ex_cond       = cond;
        rif.ex_ret        = ret;
        rif.ex_taken      = taken;
        rif.ex_pred_taken = pred;
        rif.ex_tgt        = tgt;
        rif.ex_fall       = fall;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_idle();
        rif.redir_ready = 1'b0;
        if_pc    = 32'h40;
        if_is_br = 1'b1;
        cyc();
        cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush); end
        total++; if (rif.redir_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rif.redir_valid); end
        total++; if (rif.redir_pc !== 32'd0) begin bad++; $display("FAIL reset_rpc got=%h want=0", rif.redir_pc); end
        total++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", br_count, mispred_count);
        end
        rst_n = 1'b1;
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", if_pred_taken); end
        if_is_br = 1'b0;
        if_pc    = 32'h7c;
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_nobr got=%b want=0", if_pred_taken); end
        if_is_br = 1'b1;
        if_pc    = 32'h40;
        cyc();
    endtask

    task automatic test_mispredict_taken();
        rif.redir_ready = 1'b1;
        ex_drive(32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h44);
        cyc();
        ex_idle();
        total++; if (rif.redir_valid !== 1'b1) begin bad++; $display("FAIL mp_rvalid got=%b want=1", rif.redir_valid); end
        total++; if (rif.redir_pc !== 32'h80) begin bad++; $display("FAIL mp_rpc got=%h want=00000080", rif.redir_pc); end
        total++; if (flush !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mp_flush1 flush=%b busy=%b want=1/1", flush, busy);
        end
        cyc();
        total++; if (rif.redir_valid !== 1'b0 || flush !== 1'b1) begin
            bad++; $display("FAIL mp_flush2 rvalid=%b flush=%b want=0/1", rif.redir_valid, flush);
        end
        cyc();
        total++; if (flush !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mp_flush3 flush=%b busy=%b want=1/1", flush, busy);
        end
        cyc();
        total++; if (flush !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL mp_flush_end flush=%b busy=%b want=0/0", flush, busy);
        end
        total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL mp_pred_after got=%b want=1", if_pred_taken); end
    endtask

    task automatic test_not_taken_saturate();
        logic [2:0] want_pred;
        want_pred = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ex_drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h44);
            cyc();
            ex_idle();
            total++; if (busy !== 1'b0 || rif.redir_valid !== 1'b0) begin
                bad++; $display("FAIL nt_noredir_%0d busy=%b rvalid=%b want=0/0", i, busy, rif.redir_valid);
            end
            total++; if (if_pred_taken !== want_pred[i]) begin
                bad++; $display("FAIL nt_pred_%0d got=%b want=%b", i, if_pred_taken, want_pred[i]);
            end
        end
        ex_drive(32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h44);
        cyc();
        total++; if (if_pred_taken !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL sat_up1 pred=%b busy=%b want=0/0", if_pred_taken, busy);
        end
        cyc();
        ex_idle();
        total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL sat_up2 got=%b want=1", if_pred_taken); end
        ex_drive(32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h54);
        cyc();
        ex_idle();
        total++; if (busy !== 1'b0 || rif.redir_valid !== 1'b0) begin
            bad++; $display("FAIL jmp_noredir busy=%b rvalid=%b want=0/0", busy, rif.redir_valid);
        end
    endtask

    task automatic test_ret_hold();
        rif.redir_ready = 1'b0;
        ex_drive(32'h60, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h5555);
        cyc();
        for (int i = 0; i < 5; i++) begin
            total++; if (rif.redir_valid !== 1'b1 || rif.redir_pc !== 32'h1234 || flush !== 1'b1) begin
                bad++; $display("FAIL ret_hold_%0d rvalid=%b rpc=%h flush=%b want=1/00001234/1",
                                i, rif.redir_valid, rif.redir_pc, flush);
            end
            if ((i % 2) == 0) begin
                ex_drive(32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 32'h999, 32'h44);
            end else begin
                ex_idle();
            end
            cyc();
        end
        ex_idle();
        total++; if (rif.redir_valid !== 1'b1 || rif.redir_pc !== 32'h1234) begin
            bad++; $display("FAIL ret_hold_last rvalid=%b rpc=%h want=1/00001234", rif.redir_valid, rif.redir_pc);
        end
        rif.redir_ready = 1'b1;
        cyc();
        total++; if (rif.redir_valid !== 1'b0 || flush !== 1'b1) begin
            bad++; $display("FAIL ret_accept rvalid=%b flush=%b want=0/1", rif.redir_valid, flush);
        end
        cyc();
        cyc();
        total++; if (busy !== 1'b0 || flush !== 1'b0) begin
            bad++; $display("FAIL ret_done busy=%b flush=%b want=0/0", busy, flush);
        end
        if_pc = 32'h40;
        #1;
        total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL ret_bht_kept got=%b want=1", if_pred_taken); end
    endtask

    task automatic test_reset_mid_redirect();
        rif.redir_ready = 1'b0;
        if_pc = 32'h44;
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rm_pred_before got=%b want=0", if_pred_taken); end
        ex_drive(32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h48);
        cyc();
        ex_idle();
        total++; if (rif.redir_valid !== 1'b1 || if_pred_taken !== 1'b1) begin
            bad++; $display("FAIL rm_in_redirect rvalid=%b pred=%b want=1/1", rif.redir_valid, if_pred_taken);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rif.redir_valid !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rm_async rvalid=%b flush=%b busy=%b want=0/0/0", rif.redir_valid, flush, busy);
        end
        total++; if (rif.redir_pc !== 32'd0) begin bad++; $display("FAIL rm_rpc got=%h want=0", rif.redir_pc); end
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rm_bht44 got=%b want=0", if_pred_taken); end
        if_pc = 32'h40;
        #1;
        total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rm_bht40 got=%b want=0", if_pred_taken); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_stats();
        logic [9:0]  mis_mask;
        logic [31:0] want_br;
        logic [31:0] want_mis;
        int          k;
        mis_mask = 10'b01_0010_0100;
        rif.redir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mis_mask[i]) begin
                ex_drive(32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b0, 32'h800, 32'h104);
                cyc();
                cyc();
            end else begin
                ex_drive(32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'(i % 2), 1'(i % 2), 32'h800, 32'h104);
                cyc();
            end
            ex_idle();
            k = 0;
            while (busy === 1'b1 && k < 20) begin
                cyc();
                k++;
            end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL stats_wait_%0d busy=%b want=0", i, busy); end
        end
`ifdef BRANCH_STATS_EN
        want_br  = 32'd10;
        want_mis = 32'd3;
`else
        want_br  = 32'd0;
        want_mis = 32'd0;
`endif
        total++; if (br_count !== want_br) begin bad++; $display("FAIL stats_br got=%0d want=%0d", br_count, want_br); end
        total++; if (mispred_count !== want_mis) begin
            bad++; $display("FAIL stats_mis got=%0d want=%0d", mispred_count, want_mis);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mispredict_taken();
        test_not_taken_saturate();
        test_ret_hold();
        test_reset_mid_redirect();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
